// File: rtl/proc_pkg.sv
// Shared definitions for the processor program path.
// Holds the loader frame header, program memory geometry, instruction width
// and the program loader state encoding.
package proc_pkg;

  localparam logic [7:0] LOADER_HEADER = 8'hA5;
  localparam int         PROG_DEPTH    = 16;
  localparam int         PROG_AW       = 4;
  localparam int         INSTR_W       = 16;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_COUNT = 3'd1,
    LD_HI    = 3'd2,
    LD_LO    = 3'd3,
    LD_CSUM  = 3'd4,
    LD_DONE  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Program loader: writer side of the 16x16-bit program memory.
// Accepts a framed byte stream (HEADER, N, N x {hi,lo}, XOR checksum) over a
// valid/ready handshake, writes each completed word to the program memory
// starting at address 0, and holds the CPU stalled while a load is underway.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/in_valid  stream byte and its valid
//   in_ready          byte accepted when in_valid & in_ready
//   mem_we/addr/wdata program memory write port, one-cycle strobe per word
//   cpu_hold          CPU must not fetch while high
//   load_done         one-cycle pulse on a good frame
//   load_err          sticky error, cleared by the next accepted header
//   words_loaded      words written in the current/last frame (0..16)
module program_loader
  import proc_pkg::*;
#(
  parameter logic [7:0] HEADER = LOADER_HEADER,
  parameter int         DEPTH  = PROG_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               mem_we,
  output logic [PROG_AW-1:0] mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [4:0]         words_loaded
);

  localparam logic [7:0] LP_DEPTH8 = 8'(DEPTH);

  loader_state_e      r_state;
  loader_state_e      w_next;
  logic               w_fire;
  logic               w_count_bad;
  logic               w_last_word;

  logic [7:0]         r_hi;
  logic [4:0]         r_n;
  logic [PROG_AW-1:0] r_addr;
  logic [7:0]         r_acc;

  logic               r_in_ready;
  logic               r_mem_we;
  logic [PROG_AW-1:0] r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;
  logic               r_cpu_hold;
  logic               r_load_done;
  logic               r_load_err;
  logic [4:0]         r_words;

  assign w_fire      = in_valid & r_in_ready;
  assign w_count_bad = (in_data == 8'd0) || (in_data > LP_DEPTH8);
  // r_words still holds the count before the word completing now.
  assign w_last_word = (5'(r_words + 5'd1) == r_n);

  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_IDLE:  if (w_fire && in_data == HEADER) w_next = LD_COUNT;
      LD_COUNT: if (w_fire) w_next = w_count_bad ? LD_IDLE : LD_HI;
      LD_HI:    if (w_fire) w_next = LD_LO;
      LD_LO:    if (w_fire) w_next = w_last_word ? LD_CSUM : LD_HI;
      LD_CSUM:  if (w_fire) w_next = (in_data == r_acc) ? LD_DONE : LD_IDLE;
      LD_DONE:  w_next = LD_IDLE;
      default:  w_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LD_IDLE;
      r_hi        <= '0;
      r_n         <= '0;
      r_addr      <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_words     <= '0;
    end else begin
      r_state     <= w_next;
      // Registered from the next state so ready drops exactly in DONE.
      r_in_ready  <= (w_next != LD_DONE);
      r_load_done <= (w_next == LD_DONE);
      r_mem_we    <= 1'b0;
      case (r_state)
        LD_IDLE: begin
          if (w_fire && in_data == HEADER) begin
            r_load_err <= 1'b0;
            r_words    <= '0;
            r_cpu_hold <= 1'b1;
          end
        end
        LD_COUNT: begin
          if (w_fire) begin
            if (w_count_bad) begin
              r_load_err <= 1'b1;
            end else begin
              r_n    <= in_data[4:0];
              r_acc  <= '0;
              r_addr <= '0;
            end
          end
        end
        LD_HI: begin
          if (w_fire) begin
            r_hi  <= in_data;
            r_acc <= r_acc ^ in_data;
          end
        end
        LD_LO: begin
          if (w_fire) begin
            r_acc       <= r_acc ^ in_data;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= {r_hi, in_data};
            r_addr      <= r_addr + 1'b1;
            r_words     <= r_words + 5'd1;
          end
        end
        LD_CSUM: begin
          // Hold stays asserted on mismatch: the memory holds a partial program.
          if (w_fire && in_data != r_acc) r_load_err <= 1'b1;
        end
        LD_DONE: begin
          r_cpu_hold <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized frames, a frame-level
// reference model and a write/done scoreboard.
module tb_program_loader;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [4:0]  words_loaded;

  program_loader #(.HEADER(8'hA5), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
    logic [4:0]  wl;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  // Frame-level model state.
  bit       exp_err   = 1'b0;
  bit       exp_hold  = 1'b0;
  int       exp_words = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or done.
  always @(negedge clk) begin
    wr_t e;
    int  n;
    if (mon_en && !rst) begin
      chk("ready_vs_done", {31'd0, in_ready}, {31'd0, ~load_done});
      if (mem_we) begin
        chk("write_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", {28'd0, mem_addr}, {28'd0, e.a});
          chk("wr_data", {16'd0, mem_wdata}, {16'd0, e.d});
          chk("wr_words", {27'd0, words_loaded}, {27'd0, e.wl});
        end
      end
      if (load_done) begin
        chk("done_expected", {31'd0, exp_done.size() > 0}, 32'd1);
        if (exp_done.size() > 0) begin
          n = exp_done.pop_front();
          chk("done_words", {27'd0, words_loaded}, n);
          chk("done_hold", {31'd0, cpu_hold}, 32'd1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 1) == 1)
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        $display("FAIL handshake_timeout: got in_ready=0 expected 1 within 50 cycles");
        $fatal(1, "handshake timeout");
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Issues a whole frame and records what the rules say must happen.
  task automatic send_frame(input logic [7:0] nb, input logic [15:0] w[16],
                            input logic [7:0] corrupt, input bit gaps);
    logic [7:0] cs;
    int n;
    exp_err = 1'b0; exp_words = 0; exp_hold = 1'b1;
    send_byte(8'hA5, gaps);
    send_byte(nb, gaps);
    if (nb == 8'd0 || nb > 8'd16) begin
      exp_err = 1'b1;
      return;
    end
    n  = int'(nb);
    cs = 8'd0;
    for (int i = 0; i < n; i++) begin
      send_byte(w[i][15:8], gaps);
      exp_wr.push_back('{a: 4'(i), d: w[i], wl: 5'(i + 1)});
      send_byte(w[i][7:0], gaps);
      cs = cs ^ w[i][15:8] ^ w[i][7:0];
      exp_words = i + 1;
    end
    if (corrupt == 8'd0) begin
      exp_done.push_back(n);
      exp_hold = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    send_byte(cs ^ corrupt, gaps);
  endtask

  task automatic post_check(input string nm);
    idle(3);
    chk({nm, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
    chk({nm, "_err"}, {31'd0, load_err}, {31'd0, exp_err});
    chk({nm, "_words"}, {27'd0, words_loaded}, exp_words);
    chk({nm, "_wr_drained"}, exp_wr.size(), 32'd0);
    chk({nm, "_done_drained"}, exp_done.size(), 32'd0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({nm, "_addr"}, {28'd0, mem_addr}, 32'd0);
    chk({nm, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    chk({nm, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({nm, "_done"}, {31'd0, load_done}, 32'd0);
    chk({nm, "_err"}, {31'd0, load_err}, 32'd0);
    chk({nm, "_words"}, {27'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    logic [15:0] w[16];
    logic [7:0]  nb, cor;
    int          kind;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Non-header bytes in idle are discarded.
    send_byte(8'h00, 1'b0);
    send_byte(8'h5A, 1'b0);
    post_check("idle_discard");

    // Directed two-word frame, then the same with a bad checksum, then good.
    w[0] = 16'h1E06; w[1] = 16'h1201;
    for (int i = 2; i < 16; i++) w[i] = 16'h0;
    send_frame(8'd2, w, 8'h00, 1'b0);
    post_check("good2");
    send_frame(8'd2, w, 8'h07, 1'b0);
    post_check("badcs2");
    send_frame(8'd2, w, 8'h00, 1'b0);
    post_check("recover2");

    // Illegal counts.
    send_frame(8'h00, w, 8'h00, 1'b0);
    post_check("count0");
    send_frame(8'h11, w, 8'h00, 1'b0);
    post_check("count11");

    // Full 16-word frame with bubbles.
    for (int i = 0; i < 16; i++) w[i] = 16'($urandom);
    send_frame(8'd16, w, 8'h00, 1'b1);
    post_check("full16");

    // Reset after the third word of a 16-word frame.
    exp_err = 1'b0; exp_words = 0; exp_hold = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'd16, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_byte(w[i][15:8], 1'b0);
      exp_wr.push_back('{a: 4'(i), d: w[i], wl: 5'(i + 1)});
      send_byte(w[i][7:0], 1'b0);
    end
    @(negedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    exp_err = 1'b0; exp_hold = 1'b0; exp_words = 0;
    post_check("after_rst");
    for (int i = 0; i < 16; i++) w[i] = 16'($urandom);
    send_frame(8'd5, w, 8'h00, 1'b0);
    post_check("fresh");

    // Randomized frames.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 2)) begin
        nb = 8'($urandom);
        if (nb == 8'hA5) nb = 8'h3C;
        send_byte(nb, 1'b1);
      end
      for (int i = 0; i < 16; i++) w[i] = 16'($urandom);
      kind = $urandom_range(0, 9);
      nb   = 8'($urandom_range(1, 16));
      cor  = 8'h00;
      if (kind == 0) nb = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(17, 255));
      else if (kind <= 2) cor = 8'($urandom_range(1, 255));
      send_frame(nb, w, cor, $urandom_range(0, 1) == 1);
      post_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the 16×16-bit program memory. It accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the program memory write port starting at address 0. It holds the CPU in reset-like stall (`cpu_hold`) while a load is in progress, so a new program can replace the one built in at synthesis time without reprogramming the FPGA.

## Interface
Parameters:
- `HEADER`, 8'hA5, frame start byte.
- `DEPTH`, 16, program memory depth in words (address width 4).

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts the byte this cycle when `in_valid & in_ready`.
- `mem_we`  out  1  program memory write strobe, one cycle per word.
- `mem_addr`  out  4  write address.
- `mem_wdata`  out  16  instruction word, `{hi,lo}`.
- `cpu_hold`  out  1  CPU must not fetch or advance PC while high.
- `load_done`  out  1  one-cycle pulse on a successful frame.
- `load_err`  out  1  sticky error flag; cleared at next accepted header.
- `words_loaded`  out  5  words written in current/last frame (0..16).

## Operation
- Frame: `HEADER`, `N` (1..16), then N×(hi byte, lo byte), then checksum = XOR of all 2N data bytes.
- States: IDLE, COUNT, HI, LO, CSUM, DONE.
  - IDLE: bytes ≠ `HEADER` are consumed and discarded. `HEADER` → COUNT; clear `load_err` and `words_loaded`; set `cpu_hold`.
  - COUNT: N=0 or N>16 → set `load_err`, go to IDLE, `cpu_hold` stays 1. Otherwise latch N, clear the checksum accumulator and address, and go to HI.
  - HI: latch byte, XOR into accumulator → LO.
  - LO: latch byte, XOR into accumulator, issue write, increment address/`words_loaded`. Go to CSUM after the Nth word, otherwise HI.
  - CSUM: byte == accumulator → DONE. Mismatch → set `load_err`, go to IDLE with `cpu_hold` kept at 1.
  - DONE: pulse `load_done`, drop `cpu_hold`, go to IDLE.
- Words are written as they complete; no rollback on error. `cpu_hold` is therefore released only by a fully good frame.
- Address increments mod 16. N≤16 guarantees no wrap within a frame.
- `in_ready` = 1 in every state except DONE.

## Timing
- Reset values: `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `load_done`=0, `load_err`=0, `words_loaded`=0, state IDLE.
- All outputs are registered.
- `mem_we`/`mem_addr`/`mem_wdata` are valid in the cycle after the LO byte handshake, for exactly one cycle. `mem_addr` = word index (first word → 0).
- `words_loaded` updates in the same cycle as `mem_we`.
- `cpu_hold` rises the cycle after the header handshake. It falls the cycle after DONE, coincident with the end of the `load_done` pulse. `load_done` is high exactly during DONE.
- `load_err` rises the cycle after the offending COUNT/CSUM handshake.
- Throughput: one byte per cycle with `in_valid` held high. Frame of N words occupies 2N+3 accepted bytes plus 1 DONE cycle.
- Bubbles (`in_valid`=0) hold state indefinitely; there is no timeout.
- `rst` mid-frame: immediate return to reset values. Words already written remain in memory.
- `HEADER` value inside a frame is treated as data (no resync).

## Structure
- Shared package `proc_pkg`: `LOADER_HEADER`, `PROG_DEPTH`, `PROG_AW`=4, `INSTR_W`=16, loader state enum.
- No sub-module; single FSM with datapath registers (hi byte latch, N, address, XOR accumulator). The program memory itself, a RAM with a write port and a read port matching the existing ROM interface, lives outside this block.

## Test plan
- Reset then idle: all outputs at reset values; `in_ready`=1; bytes 8'h00, 8'h5A discarded, no writes.
- Frame A5,02,1E,06,12,01,csum=1E^06^12^01=0B → writes (0,16'h1E06), (1,16'h1201); `load_done` one cycle; `cpu_hold` 1→0; `words_loaded`=2; `load_err`=0.
- Same frame with csum 0C → both writes occur, `load_err`=1, `cpu_hold` stays 1, no `load_done`. A following good frame clears `load_err` and drops hold.
- Count 00 and count 11h → `load_err`=1, zero writes, return to IDLE (next A5 accepted).
- Full 16-word frame with `in_valid` toggling randomly → writes at addresses 0..15 in order, `words_loaded`=16, correct data, `in_ready`=0 only in DONE cycle.
- `rst` asserted after 3rd word → outputs return to reset values next cycle, `cpu_hold`=0, no further writes; a fresh frame loads normally.
